// File: rtl/xbus_pkg.sv
// Shared xbus definitions: bus widths, byte-enable constant and the fetch master state encoding.
package xbus_pkg;

    localparam int XBUS_AW = 32;
    localparam int XBUS_DW = 32;
    localparam logic [3:0] XBUS_BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/xbus_sync_fifo.sv
// Synchronous FIFO with registered storage; head word is read straight from the array (no bypass).
module xbus_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/xbus_cfg_fetch.sv
// xbus read master: fetches word_count config words from base_addr, one transaction at a time,
// and streams them out of a small FIFO on a valid/ready port.
module xbus_cfg_fetch
    import xbus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [XBUS_AW-1:0]   base_addr,
    input  logic [CNT_W-1:0]     word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 xbs_select,
    output logic [XBUS_AW-1:0]   xbs_addr,
    output logic [XBUS_DW-1:0]   xbs_data,
    output logic                 xbs_rnw,
    output logic [3:0]           xbs_be,
    input  logic                 sl_ack,
    input  logic [XBUS_DW-1:0]   sl_data,
    output logic [XBUS_DW-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    fetch_state_t         state, state_nxt;
    logic [XBUS_AW-1:0]   addr;
    logic [CNT_W-1:0]     remaining;
    logic [TW-1:0]        timer;
    logic [FCW-1:0]       fifo_count;
    logic                 push;
    logic                 timeout_hit;

    assign push = (state == WAIT) && sl_ack;

    always_comb begin
        state_nxt   = state;
        xbs_select  = 1'b0;
        done        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = (word_count == '0) ? FIN : REQ;
            // Only request when the returning word is guaranteed a FIFO slot.
            REQ: if (fifo_count < FCW'(FIFO_DEPTH)) begin
                xbs_select = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (sl_ack)
                    state_nxt = (remaining == CNT_W'(1)) ? FIN : REQ;
                else if (TIMEOUT != 0 && timer == TMAX) begin
                    timeout_hit = 1'b1;
                    state_nxt   = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            timer     <= '0;
            error     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                addr      <= base_addr;
                remaining <= word_count;
                error     <= 1'b0;
            end
            if (state == REQ)
                timer <= '0;
            if (state == WAIT) begin
                if (sl_ack) begin
                    addr      <= addr + 32'd1;
                    remaining <= remaining - CNT_W'(1);
                end else begin
                    timer <= timer + TW'(1);
                end
            end
            if (timeout_hit)
                error <= 1'b1;
        end
    end

    assign busy     = (state != IDLE);
    assign xbs_addr = xbs_select ? addr : '0;
    assign xbs_be   = xbs_select ? XBUS_BE_ALL : 4'h0;
    assign xbs_data = '0;
    assign xbs_rnw  = 1'b1;

    xbus_sync_fifo #(
        .WIDTH (XBUS_DW),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sl_data),
        .pop   (m_valid && m_ready),
        .dout  (m_data),
        .valid (m_valid),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_xbus_cfg_fetch.sv
// Bench for xbus_cfg_fetch with a delayed-ack memory model and an output-stream scoreboard.
module tb_xbus_cfg_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error, xbs_select, xbs_rnw, m_valid;
    logic [31:0] xbs_addr, xbs_data, m_data;
    logic [3:0]  xbs_be;
    logic        sl_ack = 1'b0;
    logic [31:0] sl_data = '0;
    logic        m_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int sel_count = 0;
    logic prev_sel = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    int mem_delay = 1;
    bit ack_en = 1'b1;
    int pend = 0;
    logic [31:0] paddr = '0;

    xbus_cfg_fetch #(.FIFO_DEPTH(4), .TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .error(error), .xbs_select(xbs_select), .xbs_addr(xbs_addr),
        .xbs_data(xbs_data), .xbs_rnw(xbs_rnw), .xbs_be(xbs_be), .sl_ack(sl_ack),
        .sl_data(sl_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Memory model: mem[k] = C0DE_0000 + k, ack mem_delay cycles after a sampled select.
    always @(posedge clk) begin
        sl_ack <= 1'b0;
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                sl_ack  <= ack_en;
                sl_data <= 32'hC0DE_0000 + paddr;
            end
        end
        if (xbs_select) begin
            if (mem_delay <= 1) begin
                sl_ack  <= ack_en;
                sl_data <= 32'hC0DE_0000 + xbs_addr;
            end else begin
                pend  <= mem_delay - 1;
                paddr <= xbs_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_count++;
        if (xbs_select) begin
            sel_count++;
            addr_q.push_back(xbs_addr);
            checks++;
            if (prev_sel !== 1'b0 || xbs_be !== 4'hF) begin
                errors++;
                $display("FAIL select_pulse: prev_sel=%0b be=%h, required prev_sel=0 be=f", prev_sel, xbs_be);
            end
        end
        prev_sel = xbs_select;
        if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got %h with no word expected", m_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL stream_data: got %h, required %h", m_data, e);
                end
            end
        end
    end

    task automatic start_job(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = b + 32'(i);
            exp_q.push_back(32'hC0DE_0000 + a);
        end
    endtask

    task automatic wait_done(input int limit, input string name, output int cyc);
        cyc = 0;
        checks++;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc >= limit) begin
                errors++;
                $display("FAIL %s_done_timeout: no done after %0d cycles, required done", name, cyc);
                break;
            end
        end
    endtask

    task automatic wait_select(input int limit, input string name);
        int cyc;
        cyc = 0;
        checks++;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (xbs_select) break;
            if (cyc >= limit) begin
                errors++;
                $display("FAIL %s_select_timeout: no select after %0d cycles, required select", name, cyc);
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        checks++;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() == 0 && !m_valid) break;
            if (cyc >= 200) begin
                errors++;
                $display("FAIL %s_drain: %0d words still expected, m_valid=%0b, required 0/0", name, exp_q.size(), m_valid);
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [44:0] got, req;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {busy, done, error, xbs_select, xbs_addr, xbs_data[0], xbs_rnw, xbs_be, m_valid};
        req = {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0};
        checks++;
        if (got !== req || xbs_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h data=%h, required %h data=0", got, xbs_data, req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%0b m_valid=%0b, required 0/0", busy, m_valid);
        end
    endtask

    task automatic test_basic;
        int d0, cyc;
        m_ready = 1'b1;
        d0 = done_count;
        push_exp(32'h10, 4);
        start_job(32'h10, 16'd4);
        wait_done(100, "basic", cyc);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL basic_error: error=%0b, required 0", error);
        end
        drain("basic");
        checks++;
        if (done_count - d0 != 1) begin
            errors++;
            $display("FAIL basic_done_pulses: %0d, required 1", done_count - d0);
        end
    endtask

    task automatic test_zero_count;
        int s0, cyc;
        s0 = sel_count;
        start_job(32'h55, 16'd0);
        wait_done(3, "zero", cyc);
        repeat (4) @(negedge clk);
        checks++;
        if (sel_count != s0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_select: selects=%0d busy=%0b, required 0/0", sel_count - s0, busy);
        end
    endtask

    task automatic test_back_to_back;
        int s0, d0, cyc;
        m_ready = 1'b0;
        s0 = sel_count;
        d0 = done_count;
        push_exp(32'h40, 8);
        start_job(32'h40, 16'd8);
        repeat (40) @(negedge clk);
        checks++;
        if (sel_count - s0 != 4 || busy !== 1'b1 || done_count != d0) begin
            errors++;
            $display("FAIL stall_selects: selects=%0d busy=%0b dones=%0d, required 4/1/0", sel_count - s0, busy, done_count - d0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_done(200, "stall", cyc);
        drain("stall");
        checks++;
        if (sel_count - s0 != 8) begin
            errors++;
            $display("FAIL stall_total_selects: %0d, required 8", sel_count - s0);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        ack_en = 1'b0;
        start_job(32'h100, 16'd2);
        wait_select(10, "timeout");
        wait_done(200, "timeout", cyc);
        checks++;
        if (cyc != 65 || error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: done %0d cycles after select, error=%0b, required 65/1", cyc, error);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: error=%0b busy=%0b, required 1/0", error, busy);
        end
        ack_en = 1'b1;
        push_exp(32'h200, 1);
        start_job(32'h200, 16'd1);
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: error=%0b busy=%0b, required 0/1", error, busy);
        end
        wait_done(50, "after_timeout", cyc);
        drain("after_timeout");
    endtask

    task automatic test_wrap;
        int cyc;
        addr_q.delete();
        push_exp(32'hFFFF_FFFE, 3);
        start_job(32'hFFFF_FFFE, 16'd3);
        wait_done(100, "wrap", cyc);
        drain("wrap");
        checks++;
        if (addr_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_count: %0d selects, required 3", addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] a;
                a = 32'hFFFF_FFFE + 32'(i);
                checks++;
                if (addr_q[i] !== a) begin
                    errors++;
                    $display("FAIL wrap_addr%0d: got %h, required %h", i, addr_q[i], a);
                end
            end
        end
    endtask

    task automatic test_reset_mid_job;
        int cyc;
        mem_delay = 2;
        start_job(32'h20, 16'd2);
        wait_select(10, "midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({busy, done, error, xbs_select, xbs_rnw, m_valid} !== 6'b000010 || xbs_addr !== 32'h0 || xbs_be !== 4'h0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%0b done=%0b err=%0b sel=%0b rnw=%0b mv=%0b addr=%h be=%h, required 0 0 0 0 1 0 0 0",
                     busy, done, error, xbs_select, xbs_rnw, m_valid, xbs_addr, xbs_be);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_late_ack: m_valid=%0b busy=%0b, required 0/0", m_valid, busy);
        end
        mem_delay = 1;
        push_exp(32'h0, 1);
        start_job(32'h0, 16'd1);
        wait_done(50, "midrst_restart", cyc);
        drain("midrst_restart");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_back_to_back();
        test_timeout();
        test_wrap();
        test_reset_mid_job();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
